// File: rtl/snn_pkg.sv
// snn_pkg
//   Shared definitions for the spiking-neuron core: default datapath widths,
//   the neuron control-state encoding and the membrane-potential bounds.
package snn_pkg;

    localparam int DEF_WEIGHT_W = 8;
    localparam int DEF_VMEM_W   = 16;
    localparam int DEF_REFRAC_W = 4;

    localparam logic signed [DEF_VMEM_W-1:0] VMEM_MAX = {1'b0, {(DEF_VMEM_W-1){1'b1}}};
    localparam logic signed [DEF_VMEM_W-1:0] VMEM_MIN = {1'b1, {(DEF_VMEM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        FIRE = 2'd2
    } neuron_state_t;

endpackage

// File: rtl/sat_add.sv
// sat_add
//   Signed saturating adder. The sum is clamped to the W-bit signed range
//   instead of wrapping.
// Ports:
//   a, b  in   W  signed operands
//   sum   out  W  signed saturated sum
module sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

    logic signed [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};

    // Overflow shows up as disagreement between the guard bit and the MSB.
    always_comb begin
        if (wide[W] != wide[W-1]) begin
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum = wide[W-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron.sv
// lif_neuron
//   Leaky integrate-and-fire neuron. Weights accumulate into vmem while IDLE,
//   a timestep strobe triggers one EVAL cycle that applies leak and compares
//   against the threshold, and a fired spike is held in FIRE until accepted.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | accepting weights, waiting for step
//   EVAL  | one cycle: leak + threshold compare, or refractory countdown
//   FIRE  | spike_valid held until spike_ready
//
// Ports:
//   clock, resetb              clock and synchronous active-low reset
//   cfg_threshold/leak_shift/refrac  quasi-static configuration
//   in_valid/in_weight/in_ready      weight stream handshake
//   step                             timestep strobe
//   spike_valid/spike_ready          spike output handshake
//   vmem, refrac_active, step_miss   status
module lif_neuron
    import snn_pkg::*;
#(
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int VMEM_W   = DEF_VMEM_W,
    parameter int REFRAC_W = DEF_REFRAC_W
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic [VMEM_W-1:0]   cfg_threshold,
    input  logic [3:0]          cfg_leak_shift,
    input  logic [REFRAC_W-1:0] cfg_refrac,
    input  logic                in_valid,
    input  logic [WEIGHT_W-1:0] in_weight,
    output logic                in_ready,
    input  logic                step,
    output logic                spike_valid,
    input  logic                spike_ready,
    output logic [VMEM_W-1:0]   vmem,
    output logic                refrac_active,
    output logic                step_miss
);

    neuron_state_t             state, state_next;
    logic signed [VMEM_W-1:0]  vmem_q, vmem_next;
    logic [REFRAC_W-1:0]       refrac_cnt, refrac_next;
    logic                      step_miss_q;

    logic signed [VMEM_W-1:0]  weight_ext;
    logic signed [VMEM_W-1:0]  vmem_acc;
    logic signed [VMEM_W-1:0]  leak;
    logic signed [VMEM_W-1:0]  v_leak;

    assign weight_ext = {{(VMEM_W-WEIGHT_W){in_weight[WEIGHT_W-1]}}, in_weight};

    sat_add #(.W(VMEM_W)) u_sat_add (
        .a   (vmem_q),
        .b   (weight_ext),
        .sum (vmem_acc)
    );

    // Arithmetic shift magnitude never exceeds |vmem|, so the subtraction
    // moves toward zero and cannot overflow. Shift 0 cancels vmem entirely.
    assign leak   = vmem_q >>> cfg_leak_shift;
    assign v_leak = vmem_q - leak;

    assign in_ready      = (state == IDLE);
    assign spike_valid   = (state == FIRE);
    assign refrac_active = (refrac_cnt != '0);
    assign vmem          = vmem_q;
    assign step_miss     = step_miss_q;

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state       <= IDLE;
            vmem_q      <= '0;
            refrac_cnt  <= '0;
            step_miss_q <= 1'b0;
        end else begin
            state       <= state_next;
            vmem_q      <= vmem_next;
            refrac_cnt  <= refrac_next;
            step_miss_q <= step_miss_q | (step && (state != IDLE));
        end
    end

    always_comb begin
        state_next  = state;
        vmem_next   = vmem_q;
        refrac_next = refrac_cnt;
        case (state)
            IDLE: begin
                // Weights arriving during refractory are consumed but dropped.
                if (in_valid && !refrac_active) begin
                    vmem_next = vmem_acc;
                end
                if (step) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (refrac_active) begin
                    refrac_next = refrac_cnt - REFRAC_W'(1);
                    vmem_next   = '0;
                    state_next  = IDLE;
                end else if (v_leak >= $signed(cfg_threshold)) begin
                    vmem_next   = '0;
                    refrac_next = cfg_refrac;
                    state_next  = FIRE;
                end else begin
                    vmem_next   = v_leak;
                    state_next  = IDLE;
                end
            end
            FIRE: begin
                if (spike_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lif_neuron.sv
module tb_lif_neuron;

    logic        clock;
    logic        resetb;
    logic [15:0] cfg_threshold;
    logic [3:0]  cfg_leak_shift;
    logic [3:0]  cfg_refrac;
    logic        in_valid;
    logic [7:0]  in_weight;
    logic        in_ready;
    logic        step;
    logic        spike_valid;
    logic        spike_ready;
    logic [15:0] vmem;
    logic        refrac_active;
    logic        step_miss;

    int n_cmp = 0;
    int n_err = 0;

    lif_neuron dut (
        .clock          (clock),
        .resetb         (resetb),
        .cfg_threshold  (cfg_threshold),
        .cfg_leak_shift (cfg_leak_shift),
        .cfg_refrac     (cfg_refrac),
        .in_valid       (in_valid),
        .in_weight      (in_weight),
        .in_ready       (in_ready),
        .step           (step),
        .spike_valid    (spike_valid),
        .spike_ready    (spike_ready),
        .vmem           (vmem),
        .refrac_active  (refrac_active),
        .step_miss      (step_miss)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_weight(input int w);
        in_valid  = 1'b1;
        in_weight = 8'(w);
        tick();
        in_valid  = 1'b0;
    endtask

    // Step strobe, then the EVAL edge; returns positioned in cycle N+2.
    task automatic step_eval();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    initial begin
        resetb         = 1'b0;
        cfg_threshold  = 16'd100;
        cfg_leak_shift = 4'd3;
        cfg_refrac     = 4'd0;
        in_valid       = 1'b0;
        in_weight      = 8'd0;
        step           = 1'b0;
        spike_ready    = 1'b1;
        #1;
        tick();
        tick();
        resetb = 1'b1;

        // Reset state
        check("rst_vmem", $signed(vmem), 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_refrac", refrac_active, 0);
        check("rst_step_miss", step_miss, 0);

        // Basic fire: 3 x 40 = 120, 120 - 15 = 105 >= 100
        send_weight(40);
        check("acc_latency", $signed(vmem), 40);
        send_weight(40);
        send_weight(40);
        check("basic_acc", $signed(vmem), 120);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("basic_eval_in_ready", in_ready, 0);
        check("basic_eval_spike_early", spike_valid, 0);
        tick();
        check("basic_spike", spike_valid, 1);
        check("basic_vmem_zero", $signed(vmem), 0);
        tick();
        check("basic_back_idle", in_ready, 1);
        check("basic_spike_drop", spike_valid, 0);

        // Sub-threshold leak, weight and step together: 80 -> 60 -> 45
        cfg_leak_shift = 4'd2;
        in_valid  = 1'b1;
        in_weight = 8'd80;
        step      = 1'b1;
        tick();
        in_valid = 1'b0;
        step     = 1'b0;
        check("sub_weight_before_eval", $signed(vmem), 80);
        tick();
        check("sub_leak1", $signed(vmem), 60);
        check("sub_no_spike1", spike_valid, 0);
        step_eval();
        check("sub_leak2", $signed(vmem), 45);
        check("sub_no_spike2", spike_valid, 0);

        // Saturation
        for (int i = 0; i < 300; i++) send_weight(127);
        check("sat_pos", $signed(vmem), 32767);
        for (int i = 0; i < 600; i++) send_weight(-128);
        check("sat_neg", $signed(vmem), -32768);
        cfg_leak_shift = 4'd3;
        step_eval();
        check("sat_leak", $signed(vmem), -28672);
        check("sat_no_spike", spike_valid, 0);
        cfg_leak_shift = 4'd0;
        step_eval();
        check("leak_full", $signed(vmem), 0);
        send_weight(-5);
        cfg_leak_shift = 4'd15;
        step_eval();
        check("leak_sign_bit", $signed(vmem), -4);

        // Refractory: fire with refrac 2
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        cfg_leak_shift = 4'd3;
        cfg_refrac     = 4'd2;
        for (int i = 0; i < 4; i++) send_weight(127);
        check("ref_acc", $signed(vmem), 508);
        step_eval();
        check("ref_first_spike", spike_valid, 1);
        check("ref_active", refrac_active, 1);
        tick();
        for (int i = 0; i < 4; i++) send_weight(127);
        check("ref_weights_dropped", $signed(vmem), 0);
        step_eval();
        check("ref1_no_spike", spike_valid, 0);
        check("ref1_still_active", refrac_active, 1);
        for (int i = 0; i < 4; i++) send_weight(127);
        step_eval();
        check("ref2_no_spike", spike_valid, 0);
        check("ref2_vmem", $signed(vmem), 0);
        check("ref2_inactive", refrac_active, 0);

        // Third sequence fires; hold off the collector for backpressure
        spike_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_weight(127);
        check("ref3_acc", $signed(vmem), 508);
        step_eval();
        check("ref3_spike", spike_valid, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                step     = 1'b1;
                in_valid = 1'b1;
                in_weight = 8'd50;
            end
            tick();
            step     = 1'b0;
            in_valid = 1'b0;
            check("bp_spike_held", spike_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
        end
        check("bp_step_miss", step_miss, 1);
        check("bp_weight_ignored", $signed(vmem), 0);
        spike_ready = 1'b1;
        tick();
        check("bp_release_idle", in_ready, 1);
        check("bp_release_spike", spike_valid, 0);
        check("bp_step_miss_sticky", step_miss, 1);

        // Drain refractory, fire again, reset while FIRE
        spike_ready = 1'b0;
        step_eval();
        step_eval();
        check("drain_inactive", refrac_active, 0);
        for (int i = 0; i < 4; i++) send_weight(127);
        step_eval();
        check("rf_spike", spike_valid, 1);
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        check("rf_spike_lost", spike_valid, 0);
        check("rf_vmem", $signed(vmem), 0);
        check("rf_step_miss", step_miss, 0);
        check("rf_in_ready", in_ready, 1);
        check("rf_refrac", refrac_active, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron core for the user project area. Upstream synapse logic drives it with a stream of signed weights and a per-timestep strobe. It integrates the membrane potential, applies leak, thresholds, and enforces a refractory period. Output spikes go through a valid/ready handshake to the spike collector, whose results firmware reports on the GPIO check bits.

## Interface
- WEIGHT_W, 8: signed synaptic weight width
- VMEM_W, 16: signed membrane potential width
- REFRAC_W, 4: refractory counter width
- clock  in  1  system clock; all state updates on its rising edge
- resetb  in  1  synchronous, active-low reset; sampled on the rising edge of clock
- cfg_threshold  in  VMEM_W  signed firing threshold; quasi-static
- cfg_leak_shift  in  4  leak = vmem >>> shift; 0 means full leak (vmem→0); values ≥ VMEM_W give leak = sign bit (0 or −1)
- cfg_refrac  in  REFRAC_W  refractory length in timesteps
- in_valid  in  1  weight present
- in_weight  in  WEIGHT_W  signed weight
- in_ready  out  1  weight accepted when in_valid & in_ready
- step  in  1  one-cycle timestep strobe
- spike_valid  out  1  spike pending
- spike_ready  in  1  downstream accepts spike
- vmem  out  VMEM_W  current membrane potential (signed)
- refrac_active  out  1  refractory count > 0
- step_miss  out  1  sticky: step arrived while not IDLE

## Operation
- States: IDLE, EVAL, FIRE.
- IDLE
  - in_ready = 1.
  - On an accepted weight, vmem ← sat(vmem + sext(in_weight)), clamped to [−2^(VMEM_W−1), 2^(VMEM_W−1)−1].
  - If refrac_active, accepted weights are discarded and vmem is unchanged.
  - step → EVAL. If step and an accepted weight occur in the same cycle, the weight is applied first and EVAL sees the updated vmem.
- EVAL (one cycle, in_ready = 0)
  - If refrac_active: refrac_cnt−−, vmem ← 0, → IDLE.
  - Otherwise v' = vmem − (vmem >>> cfg_leak_shift), arithmetic shift.
  - If v' ≥ cfg_threshold (signed compare): vmem ← 0, refrac_cnt ← cfg_refrac, → FIRE.
  - Else vmem ← v', → IDLE.
- FIRE
  - spike_valid = 1, in_ready = 0.
  - On spike_valid & spike_ready → IDLE.
  - spike_valid stays asserted and stable until accepted.
- A step seen in EVAL or FIRE is dropped and sets step_miss. Only reset clears step_miss.
- Leak never overflows: |vmem >>> s| ≤ |vmem|, and the subtraction moves toward zero.

## Timing
- Reset values: state IDLE, vmem 0, refrac_cnt 0, spike_valid 0, refrac_active 0, step_miss 0. in_ready is 1 the first cycle after reset deasserts.
- in_ready and spike_valid are decoded from the registered state only. They have no combinational path from in_valid, step or spike_ready.
- Accumulate latency: a weight accepted in cycle N is visible on vmem in cycle N+1.
- step in cycle N: EVAL in N+1, spike_valid high in N+2 at the earliest.
- With spike_ready held high, the next weight is accepted in N+3.
- Reset asserted in any state, including FIRE with spike_valid high, returns all state to reset values on that edge. The pending spike is lost.
- cfg_* changes take effect on the next EVAL. They are not required to be stable mid-cycle.

## Structure
- Package snn_pkg holds:
  - the default WEIGHT_W / VMEM_W / REFRAC_W localparams;
  - the neuron_state_t enum (IDLE, EVAL, FIRE);
  - the VMEM_MAX / VMEM_MIN constants.
- One sub-module, sat_add: a parameterised signed saturating adder, reused by the synapse accumulator.

## Test plan
- Basic fire: threshold 100, shift 3, refrac 0. Weights 40, 40, 40 then step → vmem 120; v' = 105; spike_valid at step+2; vmem 0.
- Sub-threshold leak: weight 80, step, shift 2 → vmem 60. A second step → 45. No spike in either case.
- Saturation: 300 × +127 → vmem 32767. 600 × −128 → −32768. Then step with shift 3 → −28672.
- Refractory: refrac 2 after a spike. Weight +127 × 4 with step, twice → no spike, vmem 0, refrac_active falls after the 2nd EVAL. The third identical step sequence (vmem 508, shift 3 → v' 445 ≥ 100) → spike.
- Backpressure: spike_ready low for 5 cycles → spike_valid held, in_ready 0. A step during FIRE sets step_miss. spike_ready high → IDLE next cycle.
- Reset mid-FIRE: resetb low for one cycle while spike_valid = 1 → next cycle spike_valid 0, vmem 0, step_miss 0, in_ready 1.
